// File: rtl/key_capture_pkg.sv
// Shared types and constants for the key capture front end: state encoding,
// key vector width, reset values and a one-hot test.
package key_capture_pkg;

  localparam int KEY_W = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_PRESS    = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    DEBOUNCE = ST_DEBOUNCE,
    PRESS    = ST_PRESS,
    HOLD     = ST_HOLD,
    RELEASE  = ST_RELEASE
  } state_t;

  localparam logic [KEY_W-1:0] ONEHOT_RST = '0;
  localparam logic             VALID_RST  = 1'b0;
  localparam logic [KEY_W-1:0] CAND_RST   = '0;

  // Exactly one bit set; zero and multi-key vectors are rejected.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous lines,
// synchronous reset to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_onehot_capture.sv
// Debounced single-key capture feeding the 8-to-3 encoder (onehot_out -> d,
// valid -> enable). Optional auto-repeat while held: define KEY_AUTO_REPEAT_EN.
module key_onehot_capture
  import key_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] onehot_out,
  output logic             valid,
  output logic             key_held
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_onehot_capture: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  state_t           state;
  logic [KEY_W-1:0] key_s;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             rpt_fire;

  sync_2ff #(.WIDTH(KEY_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

`ifdef KEY_AUTO_REPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt;

  assign rpt_fire = (state == HOLD) && (key_s == onehot_out) && (rpt == RPT_LAST);

  // Held at zero outside HOLD so every entry starts a fresh period; a foreign
  // key pattern during HOLD freezes it.
  always_ff @(posedge clk) begin
    if (rst || state != HOLD || key_s == '0) begin
      rpt <= '0;
    end else if (key_s == onehot_out) begin
      rpt <= rpt_fire ? '0 : rpt + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= CAND_RST;
      cnt        <= '0;
      onehot_out <= ONEHOT_RST;
      valid      <= VALID_RST;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (is_onehot(key_s)) begin
            cand  <= key_s;
            cnt   <= CNT_W'(1);
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_s != cand)         state <= IDLE;
          else if (cnt == CNT_LAST)  state <= PRESS;
          else                       cnt   <= cnt + CNT_W'(1);
        end
        PRESS: begin
          onehot_out <= cand;
          valid      <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (key_s == '0) begin
            cnt   <= CNT_W'(1);
            state <= RELEASE;
          end else if (rpt_fire) begin
            valid <= 1'b1;
          end
        end
        RELEASE: begin
          if (key_s != '0)           state <= HOLD;
          else if (cnt == CNT_LAST)  state <= IDLE;
          else                       cnt   <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_held = (state == HOLD) || (state == RELEASE);

endmodule

// File: tb/tb_key_onehot_capture.sv
// Self-checking bench for key_onehot_capture: directed scenarios plus random
// key patterns, all compared cycle by cycle against a behavioural model.
module tb_key_onehot_capture;

  localparam int DEB = 4;
  localparam int RPT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_in = 8'h00;
  logic [7:0] onehot_out;
  logic       valid;
  logic       key_held;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  key_onehot_capture #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .onehot_out (onehot_out),
    .valid      (valid),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  // Model: a key is accepted after DEB identical one-hot samples taken while
  // no key is accepted, and released after DEB all-zero samples.
  logic [7:0] m_pipe1, m_pipe2, m_cand, m_out;
  bit         m_busy, m_fire, m_valid;
  int         m_run, m_rel, m_rep;

  task automatic model_edge(input bit r, input logic [7:0] k);
    logic [7:0] s;
    if (r) begin
      m_pipe1 = 0; m_pipe2 = 0; m_cand = 0; m_out = 0;
      m_busy = 0; m_fire = 0; m_valid = 0; m_run = 0; m_rel = 0; m_rep = 0;
      return;
    end
    s = m_pipe2;
    m_valid = 0;
    if (m_fire) begin
      m_fire = 0; m_valid = 1; m_out = m_cand; m_busy = 1; m_rel = 0; m_rep = 0;
    end else if (!m_busy) begin
      if (m_run == 0) begin
        if ($countones(s) == 1) begin m_cand = s; m_run = 1; end
      end else if (s != m_cand) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DEB) begin m_fire = 1; m_run = 0; end
      end
    end else if (m_rel == 0) begin
      if (s == 0) begin m_rel = 1; m_rep = 0; end
`ifdef KEY_AUTO_REPEAT_EN
      else if (s == m_out) begin
        m_rep++;
        if (m_rep == RPT) begin m_rep = 0; m_valid = 1; end
      end
`endif
    end else begin
      if (s != 0) begin m_rel = 0; m_rep = 0; end
      else begin
        m_rel++;
        if (m_rel == DEB) begin m_busy = 0; m_rel = 0; end
      end
    end
    m_pipe2 = m_pipe1;
    m_pipe1 = k;
  endtask

  // One clock: inputs already set by the caller, outputs checked at negedge.
  task automatic step();
    @(posedge clk);
    model_edge(rst, key_in);
    @(negedge clk);
    cyc++;
    tests_run += 3;
    if (valid !== m_valid) begin
      tests_failed++;
      $display("FAIL valid cyc=%0d got %b exp %b", cyc, valid, m_valid);
    end
    if (onehot_out !== m_out) begin
      tests_failed++;
      $display("FAIL onehot_out cyc=%0d got %h exp %h", cyc, onehot_out, m_out);
    end
    if (key_held !== m_busy) begin
      tests_failed++;
      $display("FAIL key_held cyc=%0d got %b exp %b", cyc, key_held, m_busy);
    end
  endtask

  task automatic release_keys(input int n);
    key_in = 8'h00;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (onehot_out !== 8'h00 || valid !== 1'b0 || key_held !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state got %h/%b/%b exp 00/0/0", onehot_out, valid, key_held);
      end
    end
    rst = 1'b0;
    release_keys(4);
    $display("[TB] test_reset done");
  endtask

  // Held key: valid rises just after edge DEB+2 counted from the first sampling
  // edge (index 0), i.e. the encoder captures it on edge DEB+3.
  task automatic press_and_measure(input logic [7:0] k, input int n,
                                   output int pulses, output int first);
    pulses = 0; first = -1;
    key_in = k;
    for (int i = 0; i < n; i++) begin
      step();
      if (valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic test_single_press();
    int pulses, first, drop;
    press_and_measure(8'h08, 20, pulses, first);
    tests_run += 3;
    if (pulses != 1) begin tests_failed++; $display("FAIL single_pulses got %0d exp 1", pulses); end
    if (first != DEB + 2) begin tests_failed++; $display("FAIL single_latency got %0d exp %0d", first, DEB + 2); end
    if (onehot_out !== 8'h08) begin tests_failed++; $display("FAIL single_out got %h exp 08", onehot_out); end
    drop = -1;
    key_in = 8'h00;
    for (int i = 0; i < 12; i++) begin
      step();
      if (drop < 0 && key_held === 1'b0) drop = i;
    end
    tests_run++;
    if (drop != DEB + 1) begin tests_failed++; $display("FAIL release_time got %0d exp %0d", drop, DEB + 1); end
    $display("[TB] test_single_press first=%0d pulses=%0d drop=%0d", first, pulses, drop);
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      key_in = ((i / 2) % 2 == 0) ? 8'h04 : 8'h00;
      step();
      if (valid === 1'b1) pulses++;
    end
    key_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid === 1'b1) pulses++;
    end
    tests_run += 2;
    if (pulses != 0) begin tests_failed++; $display("FAIL bounce_pulses got %0d exp 0", pulses); end
    if (onehot_out !== 8'h08) begin tests_failed++; $display("FAIL bounce_out got %h exp 08", onehot_out); end
    $display("[TB] test_bounce pulses=%0d", pulses);
  endtask

  task automatic test_multi_key();
    int pulses, first, held = 0;
    key_in = 8'h21;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid === 1'b1) pulses++;
      if (key_held === 1'b1) held++;
    end
    tests_run += 2;
    if (pulses != 0) begin tests_failed++; $display("FAIL multi_pulses got %0d exp 0", pulses); end
    if (held != 0) begin tests_failed++; $display("FAIL multi_held got %0d exp 0", held); end
    press_and_measure(8'h20, 14, pulses, first);
    tests_run += 3;
    if (pulses != 1) begin tests_failed++; $display("FAIL single_after_multi got %0d exp 1", pulses); end
    if (first != DEB + 2) begin tests_failed++; $display("FAIL multi_latency got %0d exp %0d", first, DEB + 2); end
    if (onehot_out !== 8'h20) begin tests_failed++; $display("FAIL multi_out got %h exp 20", onehot_out); end
    release_keys(10);
    $display("[TB] test_multi_key first=%0d", first);
  endtask

  task automatic test_reset_mid();
    int pulses, first;
    press_and_measure(8'h80, 10, pulses, first);
    rst = 1'b1;
    step();
    tests_run++;
    if (onehot_out !== 8'h00 || valid !== 1'b0 || key_held !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got %h/%b/%b exp 00/0/0", onehot_out, valid, key_held);
    end
    rst = 1'b0;
    press_and_measure(8'h80, 12, pulses, first);
    tests_run += 3;
    if (pulses != 1) begin tests_failed++; $display("FAIL post_reset_pulses got %0d exp 1", pulses); end
    if (first != DEB + 2) begin tests_failed++; $display("FAIL post_reset_latency got %0d exp %0d", first, DEB + 2); end
    if (onehot_out !== 8'h80) begin tests_failed++; $display("FAIL post_reset_out got %h exp 80", onehot_out); end
    release_keys(10);
    $display("[TB] test_reset_mid first=%0d", first);
  endtask

  task automatic test_repeat();
    int pulses, first, exp_pulses;
`ifdef KEY_AUTO_REPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    press_and_measure(8'h01, 40, pulses, first);
    tests_run += 2;
    if (pulses != exp_pulses) begin tests_failed++; $display("FAIL repeat_pulses got %0d exp %0d", pulses, exp_pulses); end
    if (first != DEB + 2) begin tests_failed++; $display("FAIL repeat_latency got %0d exp %0d", first, DEB + 2); end
    release_keys(10);
    $display("[TB] test_repeat pulses=%0d", pulses);
  endtask

  task automatic test_random();
    int steps = 0;
    logic [7:0] v;
    while (steps < 500) begin
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1, 2:    v = 8'h01 << $urandom_range(0, 7);
        default: v = 8'($urandom);
      endcase
      key_in = v;
      rst = ($urandom_range(0, 24) == 0);
      for (int i = $urandom_range(1, 12); i > 0; i--) begin
        step();
        rst = 1'b0;
        steps++;
      end
    end
    rst = 1'b0;
    release_keys(10);
    $display("[TB] test_random steps=%0d", steps);
  endtask

  initial begin
    model_edge(1'b1, 8'h00);
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/key_onehot_capture.md
Name: key_onehot_capture

Overview:
- Upstream front end for the 8-to-3 encoder stage. Takes eight raw, asynchronous push-button or switch lines.
- Synchronises and debounces the lines, and accepts only single-key presses.
- Presents a stable one-hot vector plus a one-cycle valid strobe.
- onehot_out feeds the encoder's d input and valid feeds its enable, so the encoder only ever sees legal one-hot codes.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required for press and for release (10 ms at 100 MHz); legal minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.
- REPEAT_CYCLES, 50000000, auto-repeat period; only used with KEY_AUTO_REPEAT_EN.

Ports:
- clk, input, 1, single system clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- key_in, input, 8, raw asynchronous key lines, active-high.
- onehot_out, output, 8, last accepted one-hot key vector; held until the next accepted press.
- valid, output, 1, one-cycle strobe: onehot_out has just been updated with a new press.
- key_held, output, 1, high while the accepted key is still held (HOLD/RELEASE states).

Behaviour:
- Reset values (rst sampled high): onehot_out=8'h00, valid=0, key_held=0, state=IDLE, counters=0, synchroniser flops=0.
- Synchroniser: key_in passes through 2 flops to give key_s. No logic uses key_in directly.
- "One-hot" means exactly one bit of key_s is set; 8'h00 and any multi-bit value are not one-hot.
- States: IDLE, DEBOUNCE, PRESS, HOLD, RELEASE.
- IDLE:
  - If key_s is one-hot: cand<=key_s, cnt<=1, go to DEBOUNCE.
  - Otherwise stay. Multi-key presses are silently ignored.
- DEBOUNCE:
  - If key_s!=cand: go to IDLE.
  - Else if cnt==DEBOUNCE_CYCLES-1: go to PRESS.
  - Else cnt<=cnt+1.
- PRESS (exactly 1 cycle): onehot_out<=cand registered on entry, valid=1, then go to HOLD.
- HOLD:
  - key_held=1.
  - When key_s==8'h00: cnt<=1, go to RELEASE.
  - Any nonzero key_s, including a different key or extra keys, keeps HOLD. No new press is accepted until full release.
- RELEASE:
  - key_held=1.
  - If key_s!=0: go back to HOLD.
  - Else if cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - Else cnt<=cnt+1.
- Latency: a key line held stable from the edge where key_in is first sampled produces valid high exactly DEBOUNCE_CYCLES+3 cycles later (2 synchroniser + DEBOUNCE_CYCLES samples + 1 PRESS register).
- valid is always a single-cycle pulse; onehot_out never changes except on the cycle valid is high.
- Bounce shorter than DEBOUNCE_CYCLES during press restarts qualification and produces no valid. Bounce during release returns to HOLD and produces no second valid.
- Reset mid-operation: everything returns to reset values on the next edge. A key still held after reset release is treated as a new press and produces one valid after full debounce.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - In HOLD, a repeat counter runs. Each time it reaches REPEAT_CYCLES-1 it reloads to 0 and valid pulses again with onehot_out unchanged.
  - The counter clears on entry to HOLD and whenever HOLD is left.
  - If key_s is not equal to the accepted key while in HOLD, the counter freezes and no repeats are issued.
- Undefined: no repeat counter is built. Exactly one valid per physical press.

Decomposition:
- Package key_capture_pkg holds:
  - state enum (IDLE, DEBOUNCE, PRESS, HOLD, RELEASE);
  - KEY_W=8;
  - localparams for reset values.
- Sub-module sync_2ff (parameterised width, 2-flop synchroniser, synchronous reset to 0), instantiated once for key_in.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
1. rst high 3 cycles, key_in=8'h00 -> onehot_out=8'h00, valid=0, key_held=0 throughout and after release of rst.
2. key_in=8'h08 held 20 cycles -> exactly one valid pulse 7 cycles after first sample, onehot_out=8'h08, key_held=1 until 4 cycles after synchronised release.
3. key_in toggles 8'h04/8'h00 every 2 cycles for 16 cycles, then 8'h00 -> no valid; onehot_out unchanged.
4. key_in=8'h21 (two keys) held 20 cycles -> no valid, state stays IDLE; then 8'h20 alone -> one valid, onehot_out=8'h20.
5. key_in=8'h80 accepted, then rst pulsed 1 cycle while held -> outputs clear; one new valid with 8'h80 7 cycles after rst deasserts.
6. KEY_AUTO_REPEAT_EN defined, key_in=8'h01 held 40 cycles -> first valid at cycle 7, then a valid every 10 cycles while held; none without the macro.
